// File: rtl/sram_req_arbiter.sv
// Purpose : shares one SRAM-like memory port between the instruction (inst_*) and data (data_*)
//           requesters, and routes each in-order data_ok/rdata return back to its owner.
// Latency : address phase is combinational (mem_req in the cycle of the request); responses are
//           forwarded with zero latency.
// Backpressure: a grant is held until mem_addr_ok. New grants stop while OT_DEPTH requests are outstanding.
// Ports   : clk/resetn (async, active-low); inst_* and data_* requester sides (req/wr/size/addr/wstrb/
//           wdata in, addr_ok/data_ok/rdata out); mem_* downstream port; ot_busy (requests outstanding);
//           ot_err (sticky, a return arrived with nothing outstanding).
// Option  : define ARB_ROUND_ROBIN_EN to alternate ties between requesters instead of data-over-inst.
module sram_req_arbiter #(
  parameter int OT_DEPTH = 4,
  parameter int OT_AW    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  // instruction requester
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data requester
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // downstream memory port
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  // status
  output logic        ot_busy,
  output logic        ot_err
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [OT_AW:0] LP_DEPTH = (OT_AW + 1)'(OT_DEPTH);

  state_t                r_state;
  logic                  r_gnt_id;      // 0 = inst, 1 = data
  logic [OT_DEPTH-1:0]   r_fifo;        // owner id of each outstanding request, oldest at r_rptr
  logic [OT_AW-1:0]      r_wptr;
  logic [OT_AW-1:0]      r_rptr;
  logic [OT_AW:0]        r_count;
  logic                  r_err;
`ifdef ARB_ROUND_ROBIN_EN
  logic                  r_last_gnt;
`endif

  logic w_full;
  logic w_empty;
  logic w_win_id;
  logic w_sel_id;
  logic w_mem_req;
  logic w_push;
  logic w_pop;
  logic w_head;

  assign w_full  = (r_count == LP_DEPTH);
  assign w_empty = (r_count == '0);

`ifdef ARB_ROUND_ROBIN_EN
  // On a tie, the requester that did not win the last handshake goes next.
  assign w_win_id = (inst_req & data_req) ? ~r_last_gnt : data_req;
`else
  // Fixed priority: data beats inst.
  assign w_win_id = data_req;
`endif

  assign w_sel_id = (r_state == HOLD) ? r_gnt_id : w_win_id;

  // Full blocks new grants even when a return pops in the same cycle; a held grant is
  // never blocked because it could only have been taken while not full. Gating with
  // resetn keeps the port quiet while reset is asserted, even with requesters active.
  assign w_mem_req = resetn & ((r_state == HOLD) | (~w_full & (inst_req | data_req)));

  always_comb begin
    mem_req   = w_mem_req;
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_addr  = 32'd0;
    mem_wstrb = 4'd0;
    mem_wdata = 32'd0;
    if (w_mem_req) begin
      if (w_sel_id) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_addr  = data_addr;
        mem_wstrb = data_wstrb;
        mem_wdata = data_wdata;
      end else begin
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_addr  = inst_addr;
        mem_wstrb = inst_wstrb;
        mem_wdata = inst_wdata;
      end
    end
  end

  assign w_push = w_mem_req & mem_addr_ok;
  assign w_pop  = mem_data_ok & ~w_empty;
  assign w_head = r_fifo[r_rptr];

  assign inst_addr_ok = w_push & ~w_sel_id;
  assign data_addr_ok = w_push &  w_sel_id;
  assign inst_data_ok = w_pop  & ~w_head;
  assign data_data_ok = w_pop  &  w_head;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign ot_busy      = ~w_empty;
  assign ot_err       = r_err;

  // Grant state machine.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_gnt_id <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_gnt <= 1'b1;
`endif
    end else begin
      if (r_state == IDLE) begin
        if (w_mem_req && !mem_addr_ok) begin
          r_state  <= HOLD;
          r_gnt_id <= w_win_id;
        end
      end else begin
        if (mem_addr_ok) begin
          r_state <= IDLE;
        end
      end
`ifdef ARB_ROUND_ROBIN_EN
      if (w_push) begin
        r_last_gnt <= w_sel_id;
      end
`endif
    end
  end

  // In-order owner tracking. Pointers wrap naturally since OT_DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fifo  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= w_sel_id;
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      // A return with nothing outstanding means the downstream lost sync with us.
      if (mem_data_ok && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
